// File: rtl/mem_ctrl_multiport.sv
// Multi-port byte-serial memory controller.
// Round-robin arbitration of NUM_PORTS requesters onto one external RAM port
// that moves one byte per cycle. Each transaction moves 1..DATA_W/8 bytes,
// little-endian. Reads may be sign-extended and aborted; IO writes stall
// while the IO buffer is full.
module mem_ctrl_multiport #(
    parameter int              NUM_PORTS    = 2,
    parameter int              ADDR_W       = 32,
    parameter int              DATA_W       = 32,
    parameter logic [ADDR_W-1:0] IO_ADDR_BASE = ADDR_W'('h30000),
    parameter int              LEN_W        = ((DATA_W / 8) > 1) ? $clog2(DATA_W / 8) : 1
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          io_buffer_full,
    input  logic [7:0]                    mem_din,
    output logic [7:0]                    mem_dout,
    output logic [ADDR_W-1:0]             mem_a,
    output logic                          mem_wr,
    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS-1:0]          req_wr,
    input  logic [NUM_PORTS-1:0]          req_signed,
    input  logic [NUM_PORTS*LEN_W-1:0]    req_len,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    input  logic [NUM_PORTS-1:0]          req_abort,
    output logic [NUM_PORTS-1:0]          resp_done,
    output logic [DATA_W-1:0]             resp_rdata,
    output logic                          busy
);

    localparam int NB    = DATA_W / 8;
    localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = LEN_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } state_t;

    state_t              state, state_d;
    logic [PW-1:0]       rr, rr_d;
    logic [PW-1:0]       cur_port, cur_port_d;
    logic                cur_signed, cur_signed_d;
    logic [LEN_W-1:0]    cur_len, cur_len_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [CNT_W-1:0]    cap_idx;
    logic [DATA_W-1:0]   wbuf, wbuf_d;
    logic [DATA_W-1:0]   rbuf, rbuf_d;
    logic [ADDR_W-1:0]   mem_a_d;
    logic [7:0]          mem_dout_d;
    logic                mem_wr_d;
    logic [NUM_PORTS-1:0] resp_done_d;
    logic [DATA_W-1:0]   resp_rdata_d;

    logic [NUM_PORTS-1:0] eligible;
    logic                grant;
    logic [PW-1:0]       winner;
    logic [PW-1:0]       scan_idx;

    assign busy    = (state != IDLE);
    assign cap_idx = cnt - CNT_W'(1);

    // Per-port eligibility: requesting, not just completed, and not an IO write facing a full buffer.
    always_comb begin
        // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
        eligible = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            eligible[p] = req_valid[p] && !resp_done[p] &&
                          !(req_wr[p] && (req_addr[p*ADDR_W +: ADDR_W] >= IO_ADDR_BASE) && io_buffer_full);
        end
    end

    // Round-robin pick: first eligible port scanning upward from rr+1 with wrap.
    always_comb begin
        grant    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            scan_idx = PW'((int'(rr) + i) % NUM_PORTS);
            if (!grant && eligible[scan_idx]) begin
                grant  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/RD/WR controller.
    always_comb begin
        state_d      = state;
        rr_d         = rr;
        cur_port_d   = cur_port;
        cur_signed_d = cur_signed;
        cur_len_d    = cur_len;
        cnt_d        = cnt;
        wbuf_d       = wbuf;
        rbuf_d       = rbuf;
        mem_a_d      = mem_a;
        mem_dout_d   = mem_dout;
        mem_wr_d     = 1'b0;
        resp_done_d  = '0;
        resp_rdata_d = resp_rdata;

        case (state)
            IDLE: begin
                if (grant) begin
                    rr_d         = winner;
                    cur_port_d   = winner;
                    cur_signed_d = req_signed[winner];
                    cur_len_d    = req_len[int'(winner)*LEN_W +: LEN_W];
                    wbuf_d       = req_wdata[int'(winner)*DATA_W +: DATA_W];
                    mem_a_d      = req_addr[int'(winner)*ADDR_W +: ADDR_W];
                    cnt_d        = '0;
                    if (req_wr[winner]) begin
                        mem_dout_d = req_wdata[int'(winner)*DATA_W +: 8];
                        mem_wr_d   = 1'b1;
                        state_d    = WR;
                    end else begin
                        state_d    = RD;
                    end
                end
            end

            RD: begin
                if (req_abort[cur_port]) begin
                    state_d = IDLE;
                end else begin
                    // Addresses run one cycle ahead of the returning bytes.
                    if (cnt < {1'b0, cur_len}) begin
                        mem_a_d = mem_a + ADDR_W'(1);
                    end
                    cnt_d = cnt + CNT_W'(1);
                    if (cnt != '0) begin
                        rbuf_d[int'(cap_idx)*8 +: 8] = mem_din;
                        if (cap_idx == {1'b0, cur_len}) begin
                            resp_rdata_d = rbuf_d;
                            for (int j = 0; j < NB; j++) begin
                                if (j > int'(cur_len)) begin
                                    resp_rdata_d[j*8 +: 8] = {8{cur_signed & mem_din[7]}};
                                end
                            end
                            resp_done_d[cur_port] = 1'b1;
                            state_d               = IDLE;
                        end
                    end
                end
            end

            WR: begin
                if (cnt == {1'b0, cur_len}) begin
                    resp_done_d[cur_port] = 1'b1;
                    state_d               = IDLE;
                end else begin
                    cnt_d      = cnt + CNT_W'(1);
                    mem_a_d    = mem_a + ADDR_W'(1);
                    mem_dout_d = wbuf[(int'(cnt) + 1)*8 +: 8];
                    mem_wr_d   = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers: synchronous reset, full freeze while rdy_in is low.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_in) begin
            state      <= IDLE;
            rr         <= PW'(NUM_PORTS - 1);
            cur_port   <= '0;
            cur_signed <= 1'b0;
            cur_len    <= '0;
            cnt        <= '0;
            wbuf       <= '0;
            rbuf       <= '0;
            mem_a      <= '0;
            mem_dout   <= '0;
            mem_wr     <= 1'b0;
            resp_done  <= '0;
            resp_rdata <= '0;
        end else if (rdy_in) begin
            state      <= state_d;
            rr         <= rr_d;
            cur_port   <= cur_port_d;
            cur_signed <= cur_signed_d;
            cur_len    <= cur_len_d;
            cnt        <= cnt_d;
            wbuf       <= wbuf_d;
            rbuf       <= rbuf_d;
            mem_a      <= mem_a_d;
            mem_dout   <= mem_dout_d;
            mem_wr     <= mem_wr_d;
            resp_done  <= resp_done_d;
            resp_rdata <= resp_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl_multiport.sv
// Directed testbench for mem_ctrl_multiport: two ports, 32-bit data.
module tb_mem_ctrl_multiport;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 2;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               rdy_in;
    logic               io_buffer_full;
    logic [7:0]         mem_din;
    logic [7:0]         mem_dout;
    logic [AW-1:0]      mem_a;
    logic               mem_wr;
    logic [NP-1:0]      req_valid;
    logic [NP-1:0]      req_wr;
    logic [NP-1:0]      req_signed;
    logic [NP*LW-1:0]   req_len;
    logic [NP*AW-1:0]   req_addr;
    logic [NP*DW-1:0]   req_wdata;
    logic [NP-1:0]      req_abort;
    logic [NP-1:0]      resp_done;
    logic [DW-1:0]      resp_rdata;
    logic               busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] ram [0:4095];

    mem_ctrl_multiport #(
        .NUM_PORTS    (NP),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .IO_ADDR_BASE (32'h30000),
        .LEN_W        (LW)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .io_buffer_full (io_buffer_full),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .req_valid      (req_valid),
        .req_wr         (req_wr),
        .req_signed     (req_signed),
        .req_len        (req_len),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_abort      (req_abort),
        .resp_done      (resp_done),
        .resp_rdata     (resp_rdata),
        .busy           (busy)
    );

    always #5 clk_in = ~clk_in;

    // RAM model: byte addressed in cycle t appears on mem_din in cycle t+1.
    always @(posedge clk_in) mem_din <= ram[mem_a[11:0]];

    task automatic set_port(input int p, input logic wr, input logic sgn, input logic [LW-1:0] len,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        req_wr[p]              = wr;
        req_signed[p]          = sgn;
        req_len[p*LW +: LW]    = len;
        req_addr[p*AW +: AW]   = addr;
        req_wdata[p*DW +: DW]  = wdata;
    endtask

    // One idle cycle, then a read on port p; lat = negedges until done (-1 on timeout).
    task automatic do_read(input int p, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                           input logic sgn, output logic [DW-1:0] rdata, output int lat);
        @(negedge clk_in);
        set_port(p, 1'b0, sgn, len, addr, '0);
        req_valid[p] = 1'b1;
        lat   = -1;
        rdata = 'x;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(negedge clk_in);
            if (resp_done[p]) begin
                lat   = n;
                rdata = resp_rdata;
            end
        end
        req_valid[p] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_in);
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL reset_mem_wr got=%b exp=0", mem_wr); end
        total++; if (mem_a !== 32'h0) begin bad++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
        total++; if (mem_dout !== 8'h0) begin bad++; $display("FAIL reset_mem_dout got=%h exp=0", mem_dout); end
        total++; if (resp_done !== 2'b00) begin bad++; $display("FAIL reset_done got=%b exp=00", resp_done); end
        total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_in = 1'b0;
    endtask

    task automatic test_read4();
        logic [AW-1:0] exp_a;
        logic [1:0]    exp_done;
        logic          exp_busy;
        set_port(0, 1'b0, 1'b0, 2'd3, 32'h100, '0);
        req_valid[0] = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk_in);
            exp_a    = (n <= 4) ? 32'h100 + 32'(n - 1) : 32'h103;
            exp_done = (n == 6) ? 2'b01 : 2'b00;
            exp_busy = (n <= 5);
            total++; if (mem_a !== exp_a) begin bad++; $display("FAIL read4_mem_a n=%0d got=%h exp=%h", n, mem_a, exp_a); end
            total++; if (resp_done !== exp_done) begin bad++; $display("FAIL read4_done n=%0d got=%b exp=%b", n, resp_done, exp_done); end
            total++; if (busy !== exp_busy) begin bad++; $display("FAIL read4_busy n=%0d got=%b exp=%b", n, busy, exp_busy); end
            total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL read4_mem_wr n=%0d got=%b exp=0", n, mem_wr); end
            if (n == 6) begin
                total++; if (resp_rdata !== 32'h44332211) begin bad++; $display("FAIL read4_rdata got=%h exp=44332211", resp_rdata); end
                req_valid[0] = 1'b0;
            end
        end
        @(negedge clk_in);
        total++; if (resp_done !== 2'b00) begin bad++; $display("FAIL read4_done_once got=%b exp=00", resp_done); end
        total++; if (resp_rdata !== 32'h44332211) begin bad++; $display("FAIL read4_rdata_hold got=%h exp=44332211", resp_rdata); end
    endtask

    task automatic test_read_ext();
        logic [DW-1:0] rd;
        int            lat;
        do_read(1, 32'h080, 2'd0, 1'b1, rd, lat);
        total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL ext_s1_rdata got=%h exp=ffffff80", rd); end
        total++; if (lat !== 3) begin bad++; $display("FAIL ext_s1_latency got=%0d exp=3", lat); end
        do_read(1, 32'h080, 2'd0, 1'b0, rd, lat);
        total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL ext_u1_rdata got=%h exp=00000080", rd); end
        total++; if (lat !== 3) begin bad++; $display("FAIL ext_u1_latency got=%0d exp=3", lat); end
        do_read(1, 32'h090, 2'd1, 1'b1, rd, lat);
        total++; if (rd !== 32'hFFFFA534) begin bad++; $display("FAIL ext_s2_rdata got=%h exp=ffffa534", rd); end
        total++; if (lat !== 4) begin bad++; $display("FAIL ext_s2_latency got=%0d exp=4", lat); end
        do_read(0, 32'h101, 2'd2, 1'b1, rd, lat);
        total++; if (rd !== 32'h00443322) begin bad++; $display("FAIL ext_s3_rdata got=%h exp=00443322", rd); end
        total++; if (lat !== 5) begin bad++; $display("FAIL ext_s3_latency got=%0d exp=5", lat); end
    endtask

    task automatic test_write();
        int         wr_cnt;
        logic       exp_wr;
        logic [1:0] exp_done;
        @(negedge clk_in);
        set_port(0, 1'b1, 1'b0, 2'd1, 32'h200, 32'h0000BEEF);
        req_valid[0] = 1'b1;
        wr_cnt = 0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk_in);
            exp_wr   = (n <= 2);
            exp_done = (n == 3) ? 2'b01 : 2'b00;
            if (mem_wr === 1'b1) wr_cnt++;
            total++; if (mem_wr !== exp_wr) begin bad++; $display("FAIL write_mem_wr n=%0d got=%b exp=%b", n, mem_wr, exp_wr); end
            total++; if (resp_done !== exp_done) begin bad++; $display("FAIL write_done n=%0d got=%b exp=%b", n, resp_done, exp_done); end
            if (n == 1) begin
                total++; if (mem_a !== 32'h200 || mem_dout !== 8'hEF) begin bad++; $display("FAIL write_byte0 got=%h/%h exp=200/ef", mem_a, mem_dout); end
                // Requester fields change after grant; the transfer must not notice.
                req_addr[0 +: AW]  = 32'hDEAD0000;
                req_wdata[0 +: DW] = 32'h12345678;
            end
            if (n == 2) begin
                total++; if (mem_a !== 32'h201 || mem_dout !== 8'hBE) begin bad++; $display("FAIL write_byte1 got=%h/%h exp=201/be", mem_a, mem_dout); end
            end
            if (n == 3) req_valid[0] = 1'b0;
        end
        total++; if (wr_cnt !== 2) begin bad++; $display("FAIL write_wr_cycles got=%0d exp=2", wr_cnt); end
    endtask

    task automatic test_round_robin();
        logic          exp_done0;
        logic          exp_busy;
        int            ev;
        int            ev_port [4];
        int            ev_n    [4];
        logic [DW-1:0] ev_data [4];
        int            exp_port [4] = '{1, 0, 1, 0};
        int            exp_n    [4] = '{3, 6, 9, 12};
        logic [DW-1:0] exp_data [4] = '{32'h22, 32'h11, 32'h22, 32'h11};

        // Single port held continuously: no regrant in the cycle its done is high.
        @(negedge clk_in);
        set_port(0, 1'b0, 1'b0, 2'd0, 32'h100, '0);
        req_valid[0] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk_in);
            exp_done0 = (n == 3 || n == 7);
            exp_busy  = (n == 1 || n == 2 || n == 5 || n == 6);
            total++; if (resp_done[0] !== exp_done0) begin bad++; $display("FAIL rr_single_done n=%0d got=%b exp=%b", n, resp_done[0], exp_done0); end
            total++; if (busy !== exp_busy) begin bad++; $display("FAIL rr_single_busy n=%0d got=%b exp=%b", n, busy, exp_busy); end
        end
        req_valid[0] = 1'b0;

        // Both ports held continuously: grants alternate.
        @(negedge clk_in);
        set_port(0, 1'b0, 1'b0, 2'd0, 32'h100, '0);
        set_port(1, 1'b0, 1'b0, 2'd0, 32'h101, '0);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            ev_port[k] = -1;
            ev_n[k]    = -1;
            ev_data[k] = 'x;
        end
        ev = 0;
        for (int n = 1; n <= 40 && ev < 4; n++) begin
            @(negedge clk_in);
            if (resp_done !== 2'b00) begin
                ev_port[ev] = resp_done[1] ? 1 : 0;
                ev_n[ev]    = n;
                ev_data[ev] = resp_rdata;
                ev++;
            end
        end
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            total++; if (ev_port[k] !== exp_port[k]) begin bad++; $display("FAIL rr_port k=%0d got=%0d exp=%0d", k, ev_port[k], exp_port[k]); end
            total++; if (ev_n[k] !== exp_n[k]) begin bad++; $display("FAIL rr_time k=%0d got=%0d exp=%0d", k, ev_n[k], exp_n[k]); end
            total++; if (ev_data[k] !== exp_data[k]) begin bad++; $display("FAIL rr_rdata k=%0d got=%h exp=%h", k, ev_data[k], exp_data[k]); end
        end
    endtask

    task automatic test_io_stall();
        logic       exp_busy;
        logic [1:0] exp_done;
        @(negedge clk_in);
        set_port(0, 1'b1, 1'b0, 2'd1, 32'h30000, 32'h0000A55A);
        set_port(1, 1'b0, 1'b0, 2'd3, 32'h100, '0);
        io_buffer_full = 1'b1;
        req_valid = 2'b11;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk_in);
            exp_busy = (n <= 5);
            exp_done = (n == 6) ? 2'b10 : 2'b00;
            total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL io_no_write n=%0d got=%b exp=0", n, mem_wr); end
            total++; if (busy !== exp_busy) begin bad++; $display("FAIL io_busy n=%0d got=%b exp=%b", n, busy, exp_busy); end
            total++; if (resp_done !== exp_done) begin bad++; $display("FAIL io_done n=%0d got=%b exp=%b", n, resp_done, exp_done); end
            if (n == 6) begin
                total++; if (resp_rdata !== 32'h44332211) begin bad++; $display("FAIL io_p1_rdata got=%h exp=44332211", resp_rdata); end
                req_valid[1] = 1'b0;
            end
        end
        io_buffer_full = 1'b0;
        @(negedge clk_in);
        total++; if (mem_wr !== 1'b1 || mem_a !== 32'h30000 || mem_dout !== 8'h5A) begin
            bad++; $display("FAIL io_grant got=%b/%h/%h exp=1/30000/5a", mem_wr, mem_a, mem_dout);
        end
        // Buffer fills again mid-write; the started write carries on.
        io_buffer_full = 1'b1;
        @(negedge clk_in);
        total++; if (mem_wr !== 1'b1 || mem_a !== 32'h30001 || mem_dout !== 8'hA5) begin
            bad++; $display("FAIL io_byte1 got=%b/%h/%h exp=1/30001/a5", mem_wr, mem_a, mem_dout);
        end
        @(negedge clk_in);
        total++; if (mem_wr !== 1'b0 || resp_done !== 2'b01) begin
            bad++; $display("FAIL io_done_p0 got=%b/%b exp=0/01", mem_wr, resp_done);
        end
        req_valid[0]   = 1'b0;
        io_buffer_full = 1'b0;
    endtask

    task automatic test_abort();
        logic exp_busy;
        @(negedge clk_in);
        set_port(0, 1'b0, 1'b0, 2'd3, 32'h090, '0);
        req_valid[0] = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk_in);
            exp_busy = (n <= 2);
            total++; if (busy !== exp_busy) begin bad++; $display("FAIL abort_busy n=%0d got=%b exp=%b", n, busy, exp_busy); end
            total++; if (resp_done !== 2'b00) begin bad++; $display("FAIL abort_done n=%0d got=%b exp=00", n, resp_done); end
            if (n == 1) req_abort[1] = 1'b1;
            if (n == 2) req_abort[0] = 1'b1;
            if (n == 3) begin
                req_abort    = 2'b00;
                req_valid[0] = 1'b0;
            end
        end
        total++; if (resp_rdata !== 32'h44332211) begin bad++; $display("FAIL abort_rdata_hold got=%h exp=44332211", resp_rdata); end
    endtask

    task automatic test_freeze();
        logic [AW-1:0] exp_a   [8] = '{32'h240, 32'h240, 32'h240, 32'h240, 32'h241, 32'h242, 32'h243, 32'h243};
        logic [7:0]    exp_d   [8] = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hDD};
        logic          exp_wr;
        logic [1:0]    exp_done;
        @(negedge clk_in);
        set_port(0, 1'b1, 1'b0, 2'd3, 32'h240, 32'hDDCCBBAA);
        req_abort[0] = 1'b1;
        req_valid[0] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk_in);
            exp_wr   = (n <= 7);
            exp_done = (n == 8) ? 2'b01 : 2'b00;
            total++; if (mem_wr !== exp_wr) begin bad++; $display("FAIL freeze_mem_wr n=%0d got=%b exp=%b", n, mem_wr, exp_wr); end
            total++; if (resp_done !== exp_done) begin bad++; $display("FAIL freeze_done n=%0d got=%b exp=%b", n, resp_done, exp_done); end
            if (n <= 7) begin
                total++; if (mem_a !== exp_a[n-1] || mem_dout !== exp_d[n-1]) begin
                    bad++; $display("FAIL freeze_byte n=%0d got=%h/%h exp=%h/%h", n, mem_a, mem_dout, exp_a[n-1], exp_d[n-1]);
                end
            end
            if (n == 1) rdy_in = 1'b0;
            if (n == 4) rdy_in = 1'b1;
        end
        req_valid[0] = 1'b0;
        req_abort[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        int            first_port;
        int            first_n;
        logic [DW-1:0] first_data;
        @(negedge clk_in);
        set_port(0, 1'b0, 1'b0, 2'd3, 32'h100, '0);
        req_valid[0] = 1'b1;
        repeat (2) @(negedge clk_in);
        total++; if (mem_a !== 32'h101) begin bad++; $display("FAIL rstmid_pre_mem_a got=%h exp=101", mem_a); end
        rst_in = 1'b1;
        @(negedge clk_in);
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL rstmid_mem_wr got=%b exp=0", mem_wr); end
        total++; if (mem_a !== 32'h0) begin bad++; $display("FAIL rstmid_mem_a got=%h exp=0", mem_a); end
        total++; if (mem_dout !== 8'h0) begin bad++; $display("FAIL rstmid_mem_dout got=%h exp=0", mem_dout); end
        total++; if (resp_done !== 2'b00) begin bad++; $display("FAIL rstmid_done got=%b exp=00", resp_done); end
        total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL rstmid_rdata got=%h exp=0", resp_rdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        rst_in = 1'b0;
        // After reset port 0 wins a simultaneous request.
        set_port(1, 1'b0, 1'b0, 2'd0, 32'h101, '0);
        set_port(0, 1'b0, 1'b0, 2'd0, 32'h100, '0);
        req_valid  = 2'b11;
        first_port = -1;
        first_n    = -1;
        first_data = 'x;
        for (int n = 1; n <= 10 && first_n < 0; n++) begin
            @(negedge clk_in);
            if (resp_done !== 2'b00) begin
                first_port = resp_done[1] ? 1 : 0;
                first_n    = n;
                first_data = resp_rdata;
            end
        end
        req_valid = 2'b00;
        total++; if (first_port !== 0) begin bad++; $display("FAIL rstmid_first_port got=%0d exp=0", first_port); end
        total++; if (first_n !== 3) begin bad++; $display("FAIL rstmid_first_time got=%0d exp=3", first_n); end
        total++; if (first_data !== 32'h11) begin bad++; $display("FAIL rstmid_first_rdata got=%h exp=11", first_data); end
    endtask

    initial begin
        rst_in         = 1'b1;
        rdy_in         = 1'b1;
        io_buffer_full = 1'b0;
        req_valid      = '0;
        req_wr         = '0;
        req_signed     = '0;
        req_len        = '0;
        req_addr       = '0;
        req_wdata      = '0;
        req_abort      = '0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h11;
        ram[12'h101] = 8'h22;
        ram[12'h102] = 8'h33;
        ram[12'h103] = 8'h44;
        ram[12'h080] = 8'h80;
        ram[12'h090] = 8'h34;
        ram[12'h091] = 8'hA5;

        test_reset();
        test_read4();
        test_read_ext();
        test_write();
        test_round_robin();
        test_io_stall();
        test_abort();
        test_freeze();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl_multiport.md
Name: mem_ctrl_multiport

Overview:
Parametrised successor to the single-client memory controller. It arbitrates NUM_PORTS requesters (IF, LSB, future D-cache/prefetch) onto the one byte-serial external RAM port, round-robin. Each transaction is 1..DATA_W/8 bytes, little-endian, with optional sign extension on reads. The block adds per-port abort, an IO-write stall against io_buffer_full, and clean mem_wr deassertion when idle.

Parameters:
NUM_PORTS, 2, number of requester channels (>=1)
ADDR_W, 32, address width
DATA_W, 32, max transaction width; multiple of 8; NB = DATA_W/8 bytes
IO_ADDR_BASE, 32'h30000, addresses >= this are IO space
LEN_W, $clog2(NB) (min 1), width of per-port length field

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; low = freeze
io_buffer_full  in  1  IO output buffer full
mem_din  in  8  RAM read byte
mem_dout  out  8  RAM write byte
mem_a  out  ADDR_W  RAM byte address
mem_wr  out  1  1=write this cycle
req_valid  in  NUM_PORTS  per-port request, level-held until done
req_wr  in  NUM_PORTS  1=write, 0=read
req_signed  in  NUM_PORTS  sign-extend read result
req_len  in  NUM_PORTS*LEN_W  bytes minus 1, per port
req_addr  in  NUM_PORTS*ADDR_W  start address, per port
req_wdata  in  NUM_PORTS*DATA_W  write data, per port
req_abort  in  NUM_PORTS  cancel this port's in-flight read
resp_done  out  NUM_PORTS  one-cycle completion pulse, one-hot
resp_rdata  out  DATA_W  read result, valid while resp_done has a bit set
busy  out  1  transaction in flight

Behaviour:
- Reset (synchronous, rst_in=1 at edge): state=IDLE; mem_wr=0, mem_a=0, mem_dout=0, resp_done=0, resp_rdata=0, busy=0; rr pointer=NUM_PORTS-1, so port 0 wins first. Reset mid-transaction aborts it; no done pulse.
- rdy_in=0 (and not reset): every register holds, including mem_wr.
- RAM timing: the byte for address mem_a in cycle t is on mem_din in cycle t+1.
- States: IDLE, RD, WR.
- IDLE eligibility: req_valid[p]=1, resp_done[p]=0 this cycle, and not (req_wr[p] && addr>=IO_ADDR_BASE && io_buffer_full).
- Arbitration: the first eligible port scanning from rr+1 upward with wrap wins. On grant, rr<=winner. wr/signed/len/addr/wdata are latched into internal registers, so requester fields may change after grant.
- Grant read: mem_a<=addr, mem_wr<=0, state<=RD, byte count=0. RD issues addresses A+1..A+len on successive cycles. Byte i is captured from mem_din into result[8i+7:8i]. After the last byte: upper bits fill with 0, or with bit 7 of the last byte if signed. resp_done[p]<=1 and state<=IDLE.
- Read latency: grant edge G, then done visible after edge G+len+2. Example: 4-byte read, grant edge 0, done after edge 5.
- Grant write: mem_a<=addr, mem_dout<=wdata[7:0], mem_wr<=1, state<=WR. Each following cycle presents the next byte at the next address. The edge after the last byte is presented sets mem_wr<=0, resp_done[p]<=1, state<=IDLE.
- Write bus activity: exactly len+1 consecutive mem_wr=1 cycles. An IO write is checked only at grant; io_buffer_full is ignored once WR has started.
- mem_wr is 0 in every cycle not driving a write byte. mem_a holds its last value in IDLE.
- resp_done is high for exactly one cycle. resp_rdata holds until the next read completes.
- Abort: req_abort[p]=1 while RD serves p -> state<=IDLE at the next edge, no done pulse, rr still updated. req_abort is ignored for writes and for ports not being served.
- A port with no grant keeps waiting indefinitely. Round-robin guarantees service within NUM_PORTS transactions.
- busy=1 exactly when state != IDLE.

Test Plan:
- Reset, then port0 4-byte read at 0x100 with RAM bytes 11,22,33,44 -> mem_a steps 0x100..0x103; resp_done[0] pulses once; resp_rdata=0x44332211; latency as specified.
- Port1 1-byte signed read of 0x80 -> rdata=0xFFFFFF80; unsigned -> 0x00000080.
- Port0 2-byte write 0xBEEF at 0x200 -> mem_wr=1 for exactly 2 cycles: (0x200,EF),(0x201,BE); then done; mem_wr=0 after.
- Both ports request continuously -> grants alternate 0,1,0,1; neither is granted twice back-to-back; the port whose done is high is not regranted in the done cycle.
- Port0 writes 0x30000 with io_buffer_full=1 while port1 reads -> port1 served, port0 waits; port0 granted the first IDLE cycle after full drops.
- Abort port0 read mid-transfer, rdy_in low for 3 cycles mid-write, and rst_in mid-read -> no done pulse, the frozen write resumes unchanged, and all outputs reach reset values at the reset edge.
